// File: rtl/wide_add_sequencer.sv
// Byte-serial wide adder: one shared 8-bit slice walks the operands LSB byte first.
// Optional macro SUB_EN adds a 'sub' input for two's-complement A-B.
module wide_add_sequencer #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
`ifdef SUB_EN
   input  logic             sub,
`endif
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             carry_out,
   output logic             overflow
);

   localparam int unsigned NB   = WIDTH / 8;
   localparam int unsigned IdxW = (NB > 1) ? $clog2(NB) : 1;
   localparam logic [IdxW-1:0] LastIdx = IdxW'(NB - 1);

   typedef enum logic [1:0] {StIdle, StAdd, StDone} state_e;

   state_e            state_q, state_d;
   logic [IdxW-1:0]   idx_q;
   logic              carry_q;
   logic [WIDTH-1:0]  a_q, b_q;
   logic [WIDTH-1:0]  result_q;
   logic              carry_out_q, overflow_q;
`ifdef SUB_EN
   logic              sub_q;
`endif

   logic              accept, last;
   logic [7:0]        a_byte, b_byte, lo, sum_byte;
   logic [1:0]        hi;

   always_ff @(posedge clk) begin
      if (rst) state_q <= StIdle;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      last    = (idx_q == LastIdx);
      unique case (state_q)
         StIdle: begin
            if (start) begin
               accept  = 1'b1;
               state_d = StAdd;
            end
         end
         StAdd:   if (last) state_d = StDone;
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Split at bit 7 so the carry into the MSB is available for signed overflow.
   always_comb begin
      a_byte = a_q[8*idx_q +: 8];
      b_byte = b_q[8*idx_q +: 8];
`ifdef SUB_EN
      if (sub_q) b_byte = ~b_byte;
`endif
      lo       = {1'b0, a_byte[6:0]} + {1'b0, b_byte[6:0]} + {7'd0, carry_q};
      hi       = {1'b0, a_byte[7]} + {1'b0, b_byte[7]} + {1'b0, lo[7]};
      sum_byte = {hi[0], lo[6:0]};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         idx_q       <= '0;
         carry_q     <= 1'b0;
         a_q         <= '0;
         b_q         <= '0;
         result_q    <= '0;
         carry_out_q <= 1'b0;
         overflow_q  <= 1'b0;
`ifdef SUB_EN
         sub_q       <= 1'b0;
`endif
      end else if (accept) begin
         a_q   <= a;
         b_q   <= b;
         idx_q <= '0;
`ifdef SUB_EN
         sub_q   <= sub;
         carry_q <= sub;
`else
         carry_q <= 1'b0;
`endif
      end else if (state_q == StAdd) begin
         result_q[8*idx_q +: 8] <= sum_byte;
         carry_q                <= hi[1];
         if (last) begin
            idx_q       <= '0;
            carry_out_q <= hi[1];
            overflow_q  <= lo[7] ^ hi[1];
         end else begin
            idx_q <= idx_q + 1'b1;
         end
      end
   end

   assign busy      = (state_q != StIdle);
   assign done      = (state_q == StDone);
   assign result    = result_q;
   assign carry_out = carry_out_q;
   assign overflow  = overflow_q;

endmodule
